mc_control_fsm: RTL and testbench

Multicycle control unit that sequences the CPU datapath: PC, memory, instruction register, register bank, ALU and ALUout, plus the PC-source, write-register and write-data muxes. It decodes the opcode and funct fields latched in the instruction register and drives every load/write enable and mux select, one instruction at a time. It sits beside the datapath inside `cpu` and is the only source of datapath control signals.

---
 rtl/mc_control_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle CPU control unit.
// Sequences PC, memory, IR, register bank, ALU/ALUout and the datapath muxes
// from the opcode/funct fields latched in the instruction register.
// Optional feature macro: CTRL_EXCEPTION_EN
//   defined   -> illegal opcode/funct traps through EXCP (EPC load + vector jump)
//   undefined -> illegal opcode/funct falls back to FETCH as a NOP, EPCWrite=0
// An illegal funct is detected in EXEC_R (the R-type execute cycle); no write
// has happened yet for that instruction, so dropping it there is side-effect free.
module mc_control_fsm #(
  parameter int unsigned MEM_WAIT       = 1,      // extra wait cycles per memory read (0..7)
  parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11   // PCSource code for the exception vector
) (
  input  logic       clk,
  input  logic       reset,      // synchronous, active-low
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCwrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       RegDest,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       EPCWrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_EXCP    = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [2:0] W_LAST = 3'(MEM_WAIT);

`ifdef CTRL_EXCEPTION_EN
  localparam state_t S_ILLEGAL = S_EXCP;
`else
  localparam state_t S_ILLEGAL = S_FETCH;
`endif

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_cnt;
  logic       w_wait_done;
  logic       w_fn_legal;
  logic [2:0] w_fn_aluop;
  // raw strobes before reset gating
  logic       w_pcwrite;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
`ifdef CTRL_EXCEPTION_EN
  logic       w_epcwrite;
`endif

  // last cycle of a memory-read state (FETCH / MEMRD)
  assign w_wait_done = (r_cnt == W_LAST);

  // R-type funct decode into ALU operation plus legality flag
  always_comb begin
    w_fn_legal = 1'b1;
    w_fn_aluop = ALU_ADD;
    case (funct)
      6'h20:   w_fn_aluop = ALU_ADD;
      6'h22:   w_fn_aluop = ALU_SUB;
      6'h24:   w_fn_aluop = ALU_AND;
      6'h25:   w_fn_aluop = ALU_OR;
      6'h2A:   w_fn_aluop = ALU_SLT;
      default: w_fn_legal = 1'b0;
    endcase
  end

  // state register and wait counter (counter restarts on every state change)
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= 3'd0;
      end else if ((r_state == S_FETCH || r_state == S_MEMRD) && !w_wait_done) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  // next-state and control decode; everything defaults to 0 / stay
  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
`ifdef CTRL_EXCEPTION_EN
    w_epcwrite = 1'b0;
`endif
    IorD       = 1'b0;
    MemToReg   = 1'b0;
    RegDest    = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = ALU_ADD;
    PCSource   = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        if (w_wait_done) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          6'h23, 6'h2B: w_next = S_MEMADR;
          6'h00:        w_next = S_EXEC_R;
          6'h04:        w_next = S_BRANCH;
          6'h02:        w_next = S_JUMP;
          6'h08:        w_next = S_ADDI_EX;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        if (w_wait_done) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        MemToReg   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = w_fn_aluop;
        w_next  = w_fn_legal ? S_RWB : S_ILLEGAL;
      end
      S_RWB: begin
        w_regwrite = 1'b1;
        RegDest    = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALU_SUB;
        PCSource  = 2'b01;
        w_pcwrite = zero;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        PCSource  = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXCP: begin
`ifdef CTRL_EXCEPTION_EN
        w_epcwrite = 1'b1;
        PCSource   = EXC_VECTOR_SEL;
        w_pcwrite  = 1'b1;
`endif
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // strobes are held low while reset is asserted
  assign PCwrite  = reset & w_pcwrite;
  assign MemWrite = reset & w_memwrite;
  assign IRWrite  = reset & w_irwrite;
  assign RegWrite = reset & w_regwrite;
`ifdef CTRL_EXCEPTION_EN
  assign EPCWrite = reset & w_epcwrite;
`else
  assign EPCWrite = 1'b0;
`endif
  assign state    = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: two instances (MEM_WAIT=1 and MEM_WAIT=3).
// Drivers build each instruction's expected state sequence from its class
// and push per-cycle expected outputs; a monitor pops and compares.
`timescale 1ns/1ps
module tb_mc_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       iord;
    logic       memw;
    logic       irw;
    logic       regw;
    logic       m2r;
    logic       rdst;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       epcw;
  } out_t;

  typedef struct packed {
    out_t       val;
    out_t       mask;
    logic [5:0] op;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s  [2];
  logic [5:0] opcode_s [2];
  logic [5:0] funct_s  [2];
  logic       zero_s   [2];
  out_t       obs      [2];

  rec_t q0[$];
  rec_t q1[$];
  int   checks = 0;
  int   errors = 0;

  // two DUTs differing only in memory wait
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic       pcw, iord, memw, irw, regw, m2r, rdst, srca, epcw;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluop;
    logic [3:0] st;
    mc_control_fsm #(.MEM_WAIT((gi == 0) ? 1 : 3), .EXC_VECTOR_SEL(2'b11)) u_dut (
      .clk      (clk),
      .reset    (reset_s[gi]),
      .opcode   (opcode_s[gi]),
      .funct    (funct_s[gi]),
      .zero     (zero_s[gi]),
      .PCwrite  (pcw),
      .IorD     (iord),
      .MemWrite (memw),
      .IRWrite  (irw),
      .RegWrite (regw),
      .MemToReg (m2r),
      .RegDest  (rdst),
      .ALUSrcA  (srca),
      .ALUSrcB  (srcb),
      .ALUOp    (aluop),
      .PCSource (pcsrc),
      .EPCWrite (epcw),
      .state    (st)
    );
    assign obs[gi] = {st, pcw, iord, memw, irw, regw, m2r, rdst, srca, srcb, aluop, pcsrc, epcw};
  end

  // index of funct in the legal R-type list (also its ALUOp code), -1 if illegal
  function automatic int fn_idx(logic [5:0] fn);
    logic [5:0] tbl [5];
    tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int k = 0; k < 5; k++) if (tbl[k] == fn) return k;
    return -1;
  endfunction

  // expected outputs of one cycle, straight from the per-state output table
  function automatic out_t exp_out(int s, logic last, logic [5:0] fn, logic z);
    out_t o;
    o = '0;
    o.st = 4'(s);
    case (s)
      0:  begin o.srcb = 2'b01; o.pcw = last; o.irw = last; end
      1:  o.srcb = 2'b11;
      2:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      3:  o.iord = 1'b1;
      4:  begin o.regw = 1'b1; o.m2r = 1'b1; end
      5:  begin o.iord = 1'b1; o.memw = 1'b1; end
      6:  begin o.srca = 1'b1; if (fn_idx(fn) >= 0) o.aluop = 3'(fn_idx(fn)); end
      7:  begin o.regw = 1'b1; o.rdst = 1'b1; end
      8:  begin o.srca = 1'b1; o.aluop = 3'b001; o.pcsrc = 2'b01; o.pcw = z; end
      9:  begin o.pcsrc = 2'b10; o.pcw = 1'b1; end
      10: begin o.srca = 1'b1; o.srcb = 2'b10; end
      11: o.regw = 1'b1;
      12: begin o.epcw = 1'b1; o.pcsrc = 2'b11; o.pcw = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t strobe_mask();
    out_t m;
    m = '0;
    m.st = '1; m.pcw = 1'b1; m.memw = 1'b1; m.irw = 1'b1; m.regw = 1'b1; m.epcw = 1'b1;
    return m;
  endfunction

  task automatic push(int d, rec_t r);
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // one reset-low cycle: only state and strobes are defined
  task automatic push_reset_cycle(int d, int s, logic [5:0] op);
    rec_t r;
    r.val = '0;
    r.val.st = 4'(s);
    r.mask = strobe_mask();
    r.op = op;
    push(d, r);
  endtask

  // run one instruction; abort_at>=0 pulls reset low for 3 cycles at that cycle
  task automatic run_instr(int d, logic [5:0] op, logic [5:0] fn, int zmode, int abort_at);
    int   w;
    int   seq[$];
    bit   exc;
    rec_t r;
    logic z;
    w = (d == 0) ? 1 : 3;
`ifdef CTRL_EXCEPTION_EN
    exc = 1'b1;
`else
    exc = 1'b0;
`endif
    for (int i = 0; i <= w; i++) seq.push_back(0);
    seq.push_back(1);
    case (op)
      6'h23: begin
        seq.push_back(2);
        for (int i = 0; i <= w; i++) seq.push_back(3);
        seq.push_back(4);
      end
      6'h2B: begin seq.push_back(2); seq.push_back(5); end
      6'h00: begin
        seq.push_back(6);
        if (fn_idx(fn) >= 0) seq.push_back(7);
        else if (exc) seq.push_back(12);
      end
      6'h04: seq.push_back(8);
      6'h02: seq.push_back(9);
      6'h08: begin seq.push_back(10); seq.push_back(11); end
      default: if (exc) seq.push_back(12);
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      @(posedge clk); #1;
      z = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      opcode_s[d] = op;
      funct_s[d]  = fn;
      zero_s[d]   = z;
      if (i == abort_at) begin
        reset_s[d] = 1'b0;
        push_reset_cycle(d, seq[i], op);
        repeat (2) begin
          @(posedge clk); #1;
          push_reset_cycle(d, 0, op);
        end
        return;
      end
      reset_s[d] = 1'b1;
      r.val  = exp_out(seq[i], (i == w), fn, z);
      r.mask = '1;
      if (seq[i] == 6 && fn_idx(fn) < 0) r.mask.aluop = 3'b000;
      r.op   = op;
      push(d, r);
    end
  endtask

  task automatic run_all(int d);
    int         w;
    int         pick;
    logic [5:0] op, fn;
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    w = (d == 0) ? 1 : 3;
    // initial reset, two cycles
    repeat (2) begin
      @(posedge clk); #1;
      push_reset_cycle(d, 0, 6'h00);
    end
    // directed cases
    run_instr(d, 6'h23, 6'h00, 0, -1);
    run_instr(d, 6'h23, 6'h00, 0, w + 3);   // reset in first MEMRD cycle
    run_instr(d, 6'h23, 6'h00, 0, -1);
    run_instr(d, 6'h2B, 6'h00, 0, -1);
    run_instr(d, 6'h04, 6'h00, 1, -1);
    run_instr(d, 6'h04, 6'h00, 2, -1);
    run_instr(d, 6'h00, 6'h2A, 0, -1);
    run_instr(d, 6'h00, 6'h22, 0, -1);
    run_instr(d, 6'h08, 6'h00, 0, -1);
    run_instr(d, 6'h02, 6'h00, 0, -1);
    run_instr(d, 6'h3F, 6'h00, 0, -1);
    run_instr(d, 6'h00, 6'h3F, 0, -1);
    // randomized mix
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 6);
      if (pick < 6) begin
        op = ops[pick];
      end else begin
        do op = 6'($urandom_range(0, 63));
        while (op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 || op == 6'h02 || op == 6'h08);
      end
      if ($urandom_range(0, 3) != 0) fn = fns[$urandom_range(0, 4)];
      else                           fn = 6'($urandom_range(0, 63));
      run_instr(d, op, fn, 0, -1);
    end
  endtask

  // monitor: compare every expected cycle on the falling edge
  initial begin
    rec_t r;
    out_t o;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
          r = (d == 0) ? q0.pop_front() : q1.pop_front();
          o = obs[d];
          checks++;
          if (((o ^ r.val) & r.mask) !== '0) begin
            errors++;
            $display("FAIL outputs dut%0d op=%02h state got=%0d exp=%0d got=%05h exp=%05h mask=%05h",
                     d, r.op, o.st, r.val.st, o, r.val, r.mask);
          end
          checks++;
          if ((32'(o.regw) + 32'(o.memw) + 32'(o.irw)) > 1) begin
            errors++;
            $display("FAIL write_exclusive dut%0d op=%02h got regw=%b memw=%b irw=%b exp at most one",
                     d, r.op, o.regw, o.memw, o.irw);
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_s[d]  = 1'b0;
      opcode_s[d] = 6'h00;
      funct_s[d]  = 6'h00;
      zero_s[d]   = 1'b0;
    end
    fork
      run_all(0);
      run_all(1);
    join
    @(negedge clk); #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got q0=%0d q1=%0d exp 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
